// File: rtl/i_memory.sv
// MEM stage of the 5-stage MIPS pipeline: wait-stated data memory, branch select and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap word accesses whose address has nonzero alu_result[1:0].
module i_memory #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic        stall,
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        misalign
);

    localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit          HAS_WAIT = (LATENCY != 0);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_q [DEPTH];

    logic             req_c, mis_c, access_c, complete_c, stall_c, mem_we_c;
    logic [ADDR_BITS-1:0] idx_c;

    logic [1:0]  wb_ctl_q, wb_ctl_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  wreg_q, wreg_d;

    assign pcsrc  = branch & zero;
    assign req_c  = memread | memwrite;
    assign idx_c  = alu_result[ADDR_BITS+1:2];

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    assign mis_c = req_c & (alu_result[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= complete_c & mis_c;
    end
    assign misalign = misalign_q;
`else
    assign mis_c    = 1'b0;
    assign misalign = 1'b0;
`endif

    assign access_c = req_c & ~mis_c;

    // Wait-state sequencing: IDLE launches the access, BUSY counts down the remaining waits.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access_c && HAS_WAIT) begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    complete_c = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset overrides any pending access so upstream restarts cleanly.
    assign stall    = stall_c & ~rst;
    assign mem_we_c = complete_c & memwrite & ~mis_c & ~rst;

    // MEM/WB payload: real values on completion, bubble otherwise.
    always_comb begin
        wb_ctl_d    = 2'b00;
        read_data_d = '0;
        alu_d       = '0;
        wreg_d      = '0;
        if (complete_c) begin
            wb_ctl_d    = mis_c ? 2'b00 : wb_ctl;
            read_data_d = (memread & ~memwrite & ~mis_c) ? mem_q[idx_c] : 32'd0;
            alu_d       = alu_result;
            wreg_d      = five_bit_muxout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_ctl_q    <= 2'b00;
            read_data_q <= '0;
            alu_q       <= '0;
            wreg_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_ctl_q    <= wb_ctl_d;
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            wreg_q      <= wreg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[idx_c] <= rdata2;
    end

    assign wb_ctlout      = wb_ctl_q;
    assign read_data      = read_data_q;
    assign mem_alu_result = alu_q;
    assign mem_write_reg  = wreg_q;

endmodule

// File: tb/tb_i_memory.sv
// Randomized self-checking bench for i_memory against a word-array reference model.
module tb_i_memory;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_ctl;
    logic        branch, memread, memwrite, zero;
    logic [31:0] alu_result, rdata2;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc, stall, misalign;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data, mem_alu_result;
    logic [4:0]  mem_write_reg;

    logic [31:0] model [DEPTH];
    int errors = 0;
    int checks = 0;

    i_memory #(.DEPTH(DEPTH), .ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .wb_ctl(wb_ctl), .branch(branch), .memread(memread),
        .memwrite(memwrite), .zero(zero), .alu_result(alu_result), .rdata2(rdata2),
        .five_bit_muxout(five_bit_muxout), .pcsrc(pcsrc), .stall(stall),
        .wb_ctlout(wb_ctlout), .read_data(read_data), .mem_alu_result(mem_alu_result),
        .mem_write_reg(mem_write_reg), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".wb"},   32'(wb_ctlout), 32'd0);
        check({tag, ".rd"},   read_data, 32'd0);
        check({tag, ".alu"},  mem_alu_result, 32'd0);
        check({tag, ".reg"},  32'(mem_write_reg), 32'd0);
        check({tag, ".mis"},  32'(misalign), 32'd0);
    endtask

    // One instruction held in MEM until it completes; called just after a falling edge.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] wb,
                          input logic [31:0] alu, input logic [31:0] dat,
                          input logic [4:0] dst, input logic br, input logic z);
        bit          mis;
        int          lat;
        int unsigned idx;
        logic [31:0] exp_rd;
        memread = rd; memwrite = wr; wb_ctl = wb; alu_result = alu; rdata2 = dat;
        five_bit_muxout = dst; branch = br; zero = z;
`ifdef MISALIGN_TRAP_EN
        mis = (rd || wr) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        lat = ((rd || wr) && !mis) ? LAT : 0;
        idx = int'(alu[9:2]) % DEPTH;
        for (int c = 0; c <= lat; c++) begin
            #1;
            check("stall", 32'(stall), 32'(c < lat));
            check("pcsrc", 32'(pcsrc), 32'(br & z));
            @(posedge clk); #1;
            if (c < lat) begin
                check_cleared("bubble");
            end else begin
                exp_rd = (rd && !wr && !mis) ? model[idx] : 32'd0;
                check("wb_ctlout", 32'(wb_ctlout), mis ? 32'd0 : 32'(wb));
                check("read_data", read_data, exp_rd);
                check("mem_alu_result", mem_alu_result, alu);
                check("mem_write_reg", 32'(mem_write_reg), 32'(dst));
                check("misalign", 32'(misalign), 32'(mis));
                if (wr && !mis) model[idx] = dat;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int kind;
        rst = 1'b1; wb_ctl = 2'b00; branch = 1'b0; memread = 1'b0; memwrite = 1'b0;
        zero = 1'b0; alu_result = '0; rdata2 = '0; five_bit_muxout = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset0");
        check("reset0.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < int'(DEPTH); i++)
            run_op(1'b0, 1'b1, 2'b00, 32'(i * 4), $urandom, 5'd0, 1'b0, 1'b0);

        // Reset with a store pending must not write.
        rst = 1'b1; memwrite = 1'b1; alu_result = 32'h40; rdata2 = ~model[16];
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_wr");
        check("reset_wr.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0; memwrite = 1'b0;
        run_op(1'b1, 1'b0, 2'b11, 32'h40, 32'd0, 5'd3, 1'b0, 1'b0);

        // Directed store/load, pass-through, branch, wrap, misalign.
        run_op(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 2'b11, 32'h10, 32'd0, 5'd8, 1'b0, 1'b0);
        check("directed_load", read_data, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 2'b10, 32'h1234, 32'd0, 5'd4, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 5'd0, 1'b1, 1'b1);
        run_op(1'b0, 1'b0, 2'b00, 32'h0, 32'd0, 5'd0, 1'b1, 1'b0);
        run_op(1'b0, 1'b1, 2'b00, 32'h400, 32'h55, 5'd0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 2'b11, 32'h0, 32'd0, 5'd9, 1'b0, 1'b0);
        check("wrap_load", read_data, 32'h55);
        run_op(1'b1, 1'b0, 2'b11, 32'h13, 32'd0, 5'd7, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 2'b11, 32'h24, 32'h1111_2222, 5'd6, 1'b0, 1'b0);

        // Reset while a store is waiting.
        model[8] = 32'h0000_0011;
        run_op(1'b0, 1'b1, 2'b00, 32'h20, 32'h11, 5'd0, 1'b0, 1'b0);
        memwrite = 1'b1; alu_result = 32'h20; rdata2 = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared("reset_busy");
        @(negedge clk);
        rst = 1'b0; memwrite = 1'b0;
        #1;
        check("reset_busy.stall", 32'(stall), 32'd0);
        run_op(1'b1, 1'b0, 2'b11, 32'h20, 32'd0, 5'd2, 1'b0, 1'b0);
        check("reset_busy.load", read_data, 32'h11);

        // Random mix of instruction kinds.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 4));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom;
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom),
                   a, d, 5'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_memory.md
Name: i_memory

Overview:
MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs and owns the word-addressed data memory. Generates the branch-taken select for fetch and holds the MEM/WB pipeline register feeding writeback. Data memory has a configurable wait-state count. An FSM stalls the upstream pipeline until each load/store completes.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of two)
ADDR_BITS, 8, log2(DEPTH); word index = alu_result[ADDR_BITS+1:2]
LATENCY, 2, wait states per load/store (0 = single-cycle access)

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  synchronous, active-high reset
wb_ctl  input  2  WB control from EX/MEM; [1]=regwrite, [0]=memtoreg
branch  input  1  branch instruction in MEM
memread  input  1  load request
memwrite  input  1  store request
zero  input  1  ALU zero flag from EX/MEM
alu_result  input  32  ALU result / effective address
rdata2  input  32  store data
five_bit_muxout  input  5  destination register number
pcsrc  output  1  branch taken select to fetch PC mux
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM while high
wb_ctlout  output  2  registered WB control
read_data  output  32  registered load data
mem_alu_result  output  32  registered ALU result
mem_write_reg  output  5  registered destination register
misalign  output  1  registered misaligned-access flag (see optional feature)

Behaviour:
- Reset: state=IDLE, cnt=0, wb_ctlout=0, read_data=0, mem_alu_result=0, mem_write_reg=0, misalign=0. Memory contents not reset.
- pcsrc = branch & zero, combinational, independent of FSM.
- req = memread | memwrite. Address wraps modulo DEPTH; bits above ADDR_BITS+1 ignored.
- FSM states: IDLE, BUSY; cnt is a down-counter sized for LATENCY.
- IDLE, !req or LATENCY=0: access completes this edge; stall=0.
- IDLE, req, LATENCY>0: stall=1 combinationally; next state BUSY, cnt=LATENCY-1; MEM/WB loads bubble (wb_ctlout=00, other fields 0).
- BUSY: stall = (cnt!=0).
  - cnt!=0: cnt decrements; MEM/WB loads bubble.
  - cnt==0: access completes this edge; next state IDLE.
- Net effect: stall is high for exactly LATENCY cycles per access. Upstream holds all inputs stable while stall=1.
- Completion edge:
  - memwrite: mem[idx] <= rdata2.
  - read_data <= memread ? mem[idx] (pre-edge value) : 0.
  - wb_ctlout <= wb_ctl; mem_alu_result <= alu_result; mem_write_reg <= five_bit_muxout.
- memread & memwrite both high is illegal. The write is performed, read_data <= 0, and timing is unchanged.
- Non-memory instructions pass through in one cycle with read_data=0.
- Back-to-back accesses: each access incurs the full LATENCY; no overlap.
- rst during BUSY: return to IDLE next edge, pending store dropped (memory unmodified), stall=0 the following cycle, MEM/WB cleared.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: req with alu_result[1:0]!=0 → no memory access, no stall, single-cycle completion with wb_ctlout forced 00, read_data=0, misalign=1 for that one MEM/WB cycle. Aligned accesses behave normally.
- Undefined: alu_result[1:0] ignored, misalign tied 0, no extra logic.

Test Plan:
- Reset: assert rst 2 cycles with memwrite=1 → all outputs 0, stall=0, no memory write.
- Store/load, LATENCY=2: memwrite, alu_result=0x10, rdata2=0xDEADBEEF → stall high 2 cycles, then memread at 0x10, wb_ctl=11, five_bit_muxout=8 → after 2 stall cycles read_data=0xDEADBEEF, wb_ctlout=11, mem_write_reg=8; bubbles (wb_ctlout=00) during stalls.
- R-type pass-through: wb_ctl=10, alu_result=0x1234, no req → next edge mem_alu_result=0x1234, read_data=0, stall never asserted.
- Branch: branch=1, zero=1 → pcsrc=1 same cycle; zero=0 → pcsrc=0.
- Wrap and reset mid-op: store 0x55 at 0x400 then load 0x0 → 0x55. Reset during BUSY of a store 0xAA to 0x20 → later load 0x20 returns the prior value, stall=0 after reset.
- MISALIGN_TRAP_EN: memread at 0x13 → no stall, misalign=1 one cycle, wb_ctlout=00; macro undefined → reads word 0x10.
